// File: rtl/updown_counter_lim_if.sv
// rtl/updown_counter_lim_if.sv - control and status bundle for updown_counter_lim
interface updown_counter_lim_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              CLR;
  logic              LOAD;
  logic [WIDTH-1:0]  DATA;
  logic              EN;
  logic              UP;
  logic [STEP_W-1:0] STEP;
  logic [WIDTH-1:0]  LO;
  logic [WIDTH-1:0]  HI;
  logic              MODE;
  logic              OVF_CLR;
  logic [WIDTH-1:0]  COUNT;
  logic              TC;
  logic              OVF;
  logic              AT_LO;
  logic              AT_HI;

  modport master (
    output CLR, LOAD, DATA, EN, UP, STEP, LO, HI, MODE, OVF_CLR,
    input  COUNT, TC, OVF, AT_LO, AT_HI
  );

  modport slave (
    input  CLR, LOAD, DATA, EN, UP, STEP, LO, HI, MODE, OVF_CLR,
    output COUNT, TC, OVF, AT_LO, AT_HI
  );
endinterface

// File: rtl/updown_counter_lim.sv
// rtl/updown_counter_lim.sv - up/down counter with step, limits, wrap/saturate policy
module updown_counter_lim #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  updown_counter_lim_if.slave bus
);
  localparam int W1 = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lo_step;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_clamped;
  logic [WIDTH-1:0] w_limit;
  logic             w_cfg_ok;
  logic             w_step_nz;
  logic             w_cross;
  logic             w_step_evt;
  logic             w_cross_evt;

  // Limit tests are done one bit wider so neither carry nor borrow can alias.
  assign w_step_ext = W1'(bus.STEP);
  assign w_sum      = {1'b0, r_count} + w_step_ext;
  assign w_lo_step  = {1'b0, bus.LO} + w_step_ext;
  assign w_diff     = r_count - w_step_ext[WIDTH-1:0];
  assign w_step_nz  = |bus.STEP;
  assign w_cfg_ok   = bus.LO <= bus.HI;

  assign w_clamped = (bus.DATA < bus.LO) ? bus.LO :
                     (bus.DATA > bus.HI) ? bus.HI : bus.DATA;

  assign w_cross = w_step_nz & (bus.UP ? (w_sum > {1'b0, bus.HI})
                                       : ({1'b0, r_count} < w_lo_step));

  // Wrap goes to the opposite limit, saturate to the approached one.
  assign w_limit = (bus.UP ~^ bus.MODE) ? bus.HI : bus.LO;

  assign w_step_evt  = bus.EN & w_cfg_ok & ~bus.CLR & ~bus.LOAD;
  assign w_cross_evt = w_step_evt & w_cross;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.CLR)
        r_count <= bus.LO;
      else if (bus.LOAD && w_cfg_ok)
        r_count <= w_clamped;
      else if (w_step_evt)
        r_count <= w_cross ? w_limit : (bus.UP ? w_sum[WIDTH-1:0] : w_diff);

      r_tc <= w_cross_evt;

      if (w_cross_evt)
        r_ovf <= 1'b1;
      else if (bus.OVF_CLR)
        r_ovf <= 1'b0;
    end
  end

  assign bus.COUNT = r_count;
  assign bus.TC    = r_tc;
  assign bus.OVF   = r_ovf;
  assign bus.AT_LO = r_count == bus.LO;
  assign bus.AT_HI = r_count == bus.HI;
endmodule

// File: doc/updown_counter_lim.md
# updown_counter_lim

Parametrised up/down counter with a programmable step, programmable lower/upper limits, and a selectable wrap or saturate policy at the limits. It adds synchronous clear, count enable, a terminal-count pulse and a sticky overflow flag beyond the basic load/increment/decrement counter. It serves as the general event/position counter in datapath and timer logic, and all outputs are registered.

## Interface
- WIDTH, 8: counter, DATA, LO and HI width (≥1).
- STEP_W, 4: STEP width (1 ≤ STEP_W ≤ WIDTH).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- CLR  in  1  synchronous clear; COUNT ← LO.
- LOAD  in  1  synchronous load of DATA (clamped, see Operation).
- DATA  in  WIDTH  load value.
- EN  in  1  count enable.
- UP  in  1  direction; 1 = add STEP, 0 = subtract STEP.
- STEP  in  STEP_W  unsigned step magnitude.
- LO  in  WIDTH  lower limit, unsigned; held static while EN=1.
- HI  in  WIDTH  upper limit, unsigned; held static while EN=1.
- MODE  in  1  limit policy; 0 = wrap, 1 = saturate.
- OVF_CLR  in  1  synchronous clear of OVF.
- COUNT  out  WIDTH  current count, registered.
- TC  out  1  terminal-count pulse, registered, one cycle.
- OVF  out  1  sticky limit-crossing flag, registered.
- AT_LO / AT_HI  out  1 each  COUNT==LO / COUNT==HI, decoded from registered COUNT.

## Operation
- Reset: COUNT=0, TC=0, OVF=0 (independent of LO/HI). AT_LO/AT_HI follow decode.
- Priority, highest first: RESET > CLR > LOAD > EN. At most one COUNT action per cycle.
- CLR: COUNT ← LO. TC=0 next cycle, OVF unaffected.
- LOAD: COUNT ← DATA if LO ≤ DATA ≤ HI. Otherwise COUNT ← LO if DATA<LO, or HI if DATA>HI. TC=0, OVF unaffected.
- EN with UP=1: sum = COUNT + STEP in WIDTH+1 bits, unsigned. Crossing event when sum > HI. No crossing: COUNT ← sum[WIDTH-1:0].
- EN with UP=0: crossing event when COUNT < LO + STEP, evaluated in WIDTH+1 bits (no borrow aliasing). No crossing: COUNT ← COUNT − STEP.
- On a crossing event:
  - MODE=0 (wrap): COUNT ← opposite limit (LO when counting up, HI when counting down). No remainder is carried.
  - MODE=1 (saturate): COUNT ← limit being approached (HI up, LO down).
  - In both modes: TC=1 for one cycle, OVF ← 1.
- Saturated and still enabled toward the limit: every cycle is a crossing event. TC stays high and COUNT holds at the limit.
- STEP=0 with EN: COUNT holds, never a crossing event.
- EN=0 (no CLR/LOAD): COUNT holds, TC=0.
- Misconfiguration LO > HI: EN and LOAD are ignored (COUNT holds, TC=0). CLR still loads LO.
- OVF: set by any crossing event, cleared by OVF_CLR. Set wins when both occur in the same cycle. Only RESET or OVF_CLR clears it.
- COUNT outside [LO,HI] (after reset or a limit change): stepping follows the same rules. An out-of-range value counting away from the nearer limit is a crossing event only by the sum/difference tests above.

## Timing
- Every action takes effect on the rising edge after the sampled inputs. COUNT, TC and OVF change in that same edge (latency 1).
- TC is asserted in the cycle following the edge on which the crossing was evaluated, i.e. coincident with the wrapped/saturated COUNT value.
- AT_LO/AT_HI are combinational from registered COUNT and the LO/HI inputs. No extra latency.
- RESET assertion clears all outputs immediately, mid-count. The first action is taken on the first rising edge after RESET deasserts.
- LO/HI/STEP/MODE/UP are sampled each edge. Changing them with EN=0 takes effect on the next enabled cycle.

## Test plan
- WIDTH=8, reset then LO=10, HI=20, STEP=3, UP=1, MODE=0, EN=1 from CLR → COUNT 10,13,16,19,10. TC high only with the second 10, OVF=1 thereafter.
- Same configuration with MODE=1 → COUNT 10,13,16,19,20,20. TC high on each 20 cycle. OVF_CLR with no crossing → OVF 0; OVF_CLR during saturation → OVF stays 1.
- UP=0, STEP=4, LO=0, HI=255, COUNT loaded 5, MODE=0 → 1, then 255 (TC=1). The 1−4 borrow is not taken as valid.
- LOAD DATA=30 with LO=10, HI=20 → COUNT=20. LOAD DATA=3 → 10. LOAD, CLR and EN together → COUNT=LO (CLR wins).
- LO=50, HI=40 with EN=1 and LOAD=1 → COUNT unchanged, TC=0. CLR → COUNT=50.
- RESET pulsed asynchronously between edges mid-count → COUNT, TC and OVF are 0 before the next edge, and counting resumes from 0 after release.
